// File: rtl/target_setting_entry.sv
// Operator target entry: debounced buttons edit 3+2 BCD digits, then hand them off via start_req/start_ack.
// Latency: press event 2+DEBOUNCE_MS cycles after a stable raw edge; outputs update one cycle after the event.
// Backpressure: start_req holds until start_ack; targets frozen until EDIT re-entered. Optional: SETTING_AUTOREPEAT_EN.
module target_setting_entry #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 200
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       btn_pos,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       edit_en,
    input  logic       start_ack,
    output logic [3:0] target_pills1,
    output logic [3:0] target_pills2,
    output logic [3:0] target_pills3,
    output logic [3:0] target_bottles1,
    output logic [3:0] target_bottles2,
    output logic [2:0] cursor,
    output logic [4:0] digit_blink,
    output logic       start_req,
    output logic       key_click,
    output logic       cfg_err
);

    typedef enum logic [1:0] {ST_EDIT, ST_REQ, ST_LOCKED} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

    // Button bit order: 0 = pos, 1 = inc, 2 = start.
    logic [2:0]      sync1, sync2, deb, deb_d, press;
    logic [DB_W-1:0] db_cnt [3];

    state_t     state;
    logic [3:0] dig [5];
    logic       accept, pos_ev, inc_ev, start_ev, rep_fire, targets_empty;
    logic [2:0] cur_nx;
    logic [3:0] dig_nx;

    function automatic logic [4:0] onehot(input logic [2:0] c);
        onehot = 5'b00001 << c;
    endfunction

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_start, btn_inc, btn_pos};
            sync2 <= sync1;
        end
    end

    // Debounced level follows the synchronized value only after DEBOUNCE_MS straight cycles of disagreement.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            deb   <= '0;
            deb_d <= '0;
            for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            deb_d <= deb;
            for (int b = 0; b < 3; b++) begin
                if (sync2[b] != deb[b]) begin
                    if (db_cnt[b] == DB_LAST) begin
                        deb[b]    <= sync2[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    assign press    = deb & ~deb_d;
    assign accept   = (state == ST_EDIT) && edit_en;
    assign pos_ev   = accept && press[0];
    assign inc_ev   = accept && (press[1] || rep_fire);
    assign start_ev = accept && press[2];

    assign cur_nx        = (cursor == 3'd4) ? 3'd0 : cursor + 3'd1;
    assign dig_nx        = (dig[cursor] == 4'd9) ? 4'd0 : dig[cursor] + 4'd1;
    assign targets_empty = ({dig[2], dig[1], dig[0]} == 12'd0) || ({dig[4], dig[3]} == 8'd0);

`ifdef SETTING_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_DLY = RP_W'(REPEAT_DELAY_MS - 1);
    localparam logic [RP_W-1:0] RP_RATE = RP_W'(REPEAT_RATE_MS - 1);

    logic            rep_on, rep_first;
    logic [RP_W-1:0] rep_cnt;

    assign rep_fire = rep_on && deb[1] && accept && (rep_cnt == (rep_first ? RP_DLY : RP_RATE));

    // Auto-repeat timer: armed by an inc press, killed by release, pos, start or leaving editable EDIT.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            rep_on    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (!accept || !deb[1] || press[0] || press[2]) begin
            rep_on <= 1'b0;
        end else if (press[1]) begin
            rep_on    <= 1'b1;
            rep_first <= 1'b1;
            rep_cnt   <= '0;
        end else if (rep_on) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY_MS + REPEAT_RATE_MS;
    assign rep_fire = 1'b0;
`endif

    // Edit/handshake state machine; all outputs registered.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state       <= ST_EDIT;
            cursor      <= 3'd0;
            start_req   <= 1'b0;
            key_click   <= 1'b0;
            cfg_err     <= 1'b0;
            digit_blink <= 5'd0;
            for (int d = 0; d < 5; d++) dig[d] <= 4'd0;
        end else begin
            key_click <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                ST_EDIT: begin
                    digit_blink <= edit_en ? onehot(cursor) : 5'd0;
                    if (start_ev) begin
                        if (targets_empty) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state       <= ST_REQ;
                            start_req   <= 1'b1;
                            key_click   <= 1'b1;
                            digit_blink <= 5'd0;
                        end
                    end else if (pos_ev || inc_ev) begin
                        key_click <= 1'b1;
                        if (inc_ev) dig[cursor] <= dig_nx;
                        if (pos_ev) begin
                            cursor      <= cur_nx;
                            digit_blink <= onehot(cur_nx);
                        end
                    end
                end
                ST_REQ: begin
                    digit_blink <= 5'd0;
                    if (start_ack) begin
                        state     <= ST_LOCKED;
                        start_req <= 1'b0;
                    end
                end
                default: begin
                    if (edit_en) begin
                        state       <= ST_EDIT;
                        digit_blink <= onehot(cursor);
                    end else begin
                        digit_blink <= 5'd0;
                    end
                end
            endcase
        end
    end

    assign target_pills1   = dig[0];
    assign target_pills2   = dig[1];
    assign target_pills3   = dig[2];
    assign target_bottles1 = dig[3];
    assign target_bottles2 = dig[4];

endmodule

// File: tb/tb_target_setting_entry.sv
// Bench for target_setting_entry: randomized button presses against a digit/cursor model.
// Latency: each press is followed by settling time before outputs are compared.
// Backpressure: start_ack driven by the bench to walk the start handshake.
module tb_target_setting_entry;

    logic       clk_1khz = 1'b0;
    logic       switch_clr = 1'b0;
    logic       btn_pos = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
    logic       edit_en = 1'b1, start_ack = 1'b0;
    logic [3:0] target_pills1, target_pills2, target_pills3, target_bottles1, target_bottles2;
    logic [2:0] cursor;
    logic [4:0] digit_blink;
    logic       start_req, key_click, cfg_err;

    int checks = 0;
    int passes = 0;
    int clicks = 0;
    int errs   = 0;

    // Reference model: plain digits, cursor and a mode word (0 edit, 1 requesting, 2 locked).
    int m_dig [5];
    int m_cur;
    int m_mode;

    target_setting_entry #(.DEBOUNCE_MS(4), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(200)) dut (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr),
        .btn_pos(btn_pos), .btn_inc(btn_inc), .btn_start(btn_start),
        .edit_en(edit_en), .start_ack(start_ack),
        .target_pills1(target_pills1), .target_pills2(target_pills2), .target_pills3(target_pills3),
        .target_bottles1(target_bottles1), .target_bottles2(target_bottles2),
        .cursor(cursor), .digit_blink(digit_blink),
        .start_req(start_req), .key_click(key_click), .cfg_err(cfg_err)
    );

    always #5 clk_1khz = ~clk_1khz;

    always @(negedge clk_1khz) begin
        if (key_click) clicks++;
        if (cfg_err) errs++;
    end

    function automatic logic [19:0] model_vec();
        return {4'(m_dig[4]), 4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {target_bottles2, target_bottles1, target_pills3, target_pills2, target_pills1};
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 5; d++) m_dig[d] = 0;
        m_cur  = 0;
        m_mode = 0;
    endfunction

    // One accepted or discarded debounced press; start takes priority over pos/inc.
    function automatic void model_press(input logic p, input logic i, input logic s);
        if (m_mode != 0 || !edit_en) return;
        if (s) begin
            if (m_dig[0] + m_dig[1] + m_dig[2] != 0 && m_dig[3] + m_dig[4] != 0) m_mode = 1;
        end else begin
            if (i) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            if (p) m_cur = (m_cur + 1) % 5;
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    task automatic press(input logic p, input logic i, input logic s, input int hold);
        @(negedge clk_1khz);
        btn_pos = p; btn_inc = i; btn_start = s;
        cyc(hold);
        btn_pos = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
        cyc(12);
    endtask

    task automatic do_reset();
        @(negedge clk_1khz);
        switch_clr = 1'b0;
        btn_pos = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; start_ack = 1'b0; edit_en = 1'b1;
        cyc(2);
        switch_clr = 1'b1;
        cyc(3);
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (dut_vec() !== 20'd0) $display("FAIL reset_digits got=%h exp=0", dut_vec()); else passes++;
        checks++; if (cursor !== 3'd0) $display("FAIL reset_cursor got=%0d exp=0", cursor); else passes++;
        checks++; if ({start_req, key_click, cfg_err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {start_req, key_click, cfg_err}); else passes++;
        checks++; if (digit_blink !== 5'd0) $display("FAIL reset_blink_in_reset got=%b exp=00000", digit_blink); else passes++;
        @(negedge clk_1khz);
        switch_clr = 1'b1;
        cyc(3);
        checks++; if (digit_blink !== 5'b00001) $display("FAIL reset_blink_after got=%b exp=00001", digit_blink); else passes++;
    endtask

    task automatic test_debounce();
        int c0;
        do_reset();
        c0 = clicks;
        press(1'b0, 1'b1, 1'b0, 3);
        press(1'b1, 1'b0, 1'b0, 2);
        checks++; if (dut_vec() !== model_vec()) $display("FAIL debounce_glitch got=%h exp=%h", dut_vec(), model_vec()); else passes++;
        checks++; if (clicks - c0 != 0) $display("FAIL debounce_glitch_click got=%0d exp=0", clicks - c0); else passes++;
        c0 = clicks;
        press(1'b0, 1'b1, 1'b0, 10);
        model_press(1'b0, 1'b1, 1'b0);
        checks++; if (target_pills1 !== 4'd1) $display("FAIL debounce_held got=%0d exp=1", target_pills1); else passes++;
        checks++; if (clicks - c0 != 1) $display("FAIL debounce_held_click got=%0d exp=1", clicks - c0); else passes++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 4; k++) begin press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0); end
        for (int k = 0; k < 2; k++) begin press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0); end
        checks++; if (target_bottles2 !== 4'd2) $display("FAIL wrap_bottles2 got=%0d exp=2", target_bottles2); else passes++;
        checks++; if (cursor !== 3'd4) $display("FAIL wrap_cursor4 got=%0d exp=4", cursor); else passes++;
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        checks++; if (cursor !== 3'd0) $display("FAIL wrap_cursor0 got=%0d exp=0", cursor); else passes++;
        for (int k = 0; k < 10; k++) begin press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0); end
        checks++; if ({target_pills2, target_pills1} !== 8'h00) $display("FAIL wrap_digit got=%h exp=00", {target_pills2, target_pills1}); else passes++;
        checks++; if (dut_vec() !== model_vec()) $display("FAIL wrap_all got=%h exp=%h", dut_vec(), model_vec()); else passes++;
    endtask

    task automatic test_random();
        int op, hold, c0, expc;
        logic p, i;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 3);
            hold = $urandom_range(7, 14);
            c0 = clicks;
            if (op == 3) begin
                p = ($urandom_range(0, 1) == 1);
                press(p, !p, 1'b0, $urandom_range(1, 3));
                expc = 0;
            end else begin
                p = (op != 1);
                i = (op != 0);
                press(p, i, 1'b0, hold);
                model_press(p, i, 1'b0);
                expc = 1;
            end
            checks++; if (dut_vec() !== model_vec()) $display("FAIL random_digits n=%0d got=%h exp=%h", n, dut_vec(), model_vec()); else passes++;
            checks++; if (cursor !== 3'(m_cur)) $display("FAIL random_cursor n=%0d got=%0d exp=%0d", n, cursor, m_cur); else passes++;
            checks++; if (clicks - c0 != expc) $display("FAIL random_click n=%0d got=%0d exp=%0d", n, clicks - c0, expc); else passes++;
            checks++; if (digit_blink !== (5'b00001 << m_cur)) $display("FAIL random_blink n=%0d got=%b cur=%0d", n, digit_blink, m_cur); else passes++;
        end
    endtask

    task automatic test_validation();
        int c0, e0;
        do_reset();
        for (int k = 0; k < 5; k++) begin press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0); end
        c0 = clicks; e0 = errs;
        press(1'b0, 1'b0, 1'b1, 8); model_press(1'b0, 1'b0, 1'b1);
        checks++; if (errs - e0 != 1) $display("FAIL valid_err got=%0d exp=1", errs - e0); else passes++;
        checks++; if (clicks - c0 != 0) $display("FAIL valid_click got=%0d exp=0", clicks - c0); else passes++;
        checks++; if (start_req !== 1'b0) $display("FAIL valid_req got=%b exp=0", start_req); else passes++;
        checks++; if (digit_blink !== 5'b00001 || m_mode != 0) $display("FAIL valid_edit got=%b exp=00001", digit_blink); else passes++;
    endtask

    task automatic test_handshake();
        int c0, t;
        logic [19:0] frozen;
        do_reset();
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0); end
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0); end
        checks++; if (dut_vec() !== 20'h03120) $display("FAIL hs_setup got=%h exp=03120", dut_vec()); else passes++;
        @(negedge clk_1khz);
        btn_start = 1'b1;
        t = 0;
        while (start_req !== 1'b1 && t < 30) begin @(negedge clk_1khz); t++; end
        checks++; if (start_req !== 1'b1 || key_click !== 1'b1) $display("FAIL hs_req_rise req=%b click=%b exp=1,1 cycles=%0d", start_req, key_click, t); else passes++;
        model_press(1'b0, 1'b0, 1'b1);
        btn_start = 1'b0;
        cyc(10);
        frozen = model_vec();
        c0 = clicks;
        press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0);
        checks++; if (dut_vec() !== frozen) $display("FAIL hs_frozen_req got=%h exp=%h", dut_vec(), frozen); else passes++;
        checks++; if (start_req !== 1'b1 || clicks - c0 != 0) $display("FAIL hs_req_hold req=%b clicks=%0d exp=1,0", start_req, clicks - c0); else passes++;
        start_ack = 1'b1;
        @(negedge clk_1khz);
        checks++; if (start_req !== 1'b0) $display("FAIL hs_req_fall got=%b exp=0", start_req); else passes++;
        m_mode = 2;
        start_ack = 1'b0;
        edit_en = 1'b0;
        press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0);
        checks++; if (dut_vec() !== frozen || digit_blink !== 5'd0) $display("FAIL hs_locked got=%h blink=%b exp=%h", dut_vec(), digit_blink, frozen); else passes++;
        edit_en = 1'b1;
        m_mode = 0;
        cyc(2);
        checks++; if (digit_blink !== 5'b01000) $display("FAIL hs_resume_blink got=%b exp=01000", digit_blink); else passes++;
        press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0);
        checks++; if (dut_vec() !== 20'h04120) $display("FAIL hs_resume_edit got=%h exp=04120", dut_vec()); else passes++;
        // Asynchronous reset while requesting must drop start_req immediately.
        @(negedge clk_1khz);
        btn_start = 1'b1;
        t = 0;
        while (start_req !== 1'b1 && t < 30) begin @(negedge clk_1khz); t++; end
        btn_start = 1'b0;
        checks++; if (start_req !== 1'b1) $display("FAIL hs_req2 got=%b exp=1", start_req); else passes++;
        @(posedge clk_1khz);
        #2 switch_clr = 1'b0;
        #1;
        checks++; if (start_req !== 1'b0 || dut_vec() !== 20'd0) $display("FAIL hs_async_reset req=%b digits=%h exp=0,0", start_req, dut_vec()); else passes++;
        cyc(2);
        switch_clr = 1'b1;
        cyc(3);
        model_reset();
    endtask

    task automatic test_simultaneous();
        int c0;
        do_reset();
        c0 = clicks;
        press(1'b1, 1'b1, 1'b0, 9); model_press(1'b1, 1'b1, 1'b0);
        checks++; if (target_pills1 !== 4'd1 || cursor !== 3'd1) $display("FAIL simul_pos_inc pills1=%0d cursor=%0d exp=1,1", target_pills1, cursor); else passes++;
        checks++; if (clicks - c0 != 1) $display("FAIL simul_click got=%0d exp=1", clicks - c0); else passes++;
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8); model_press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 8); model_press(1'b0, 1'b1, 1'b0);
        c0 = clicks;
        press(1'b1, 1'b1, 1'b1, 9); model_press(1'b1, 1'b1, 1'b1);
        checks++; if (dut_vec() !== model_vec() || cursor !== 3'(m_cur)) $display("FAIL simul_start_wins got=%h cur=%0d exp=%h cur=%0d", dut_vec(), cursor, model_vec(), m_cur); else passes++;
        checks++; if (start_req !== 1'b1 || clicks - c0 != 1) $display("FAIL simul_start_req req=%b clicks=%0d exp=1,1", start_req, clicks - c0); else passes++;
    endtask

    task automatic test_autorepeat();
        int c0, exp_inc;
`ifdef SETTING_AUTOREPEAT_EN
        exp_inc = 5;
`else
        exp_inc = 1;
`endif
        do_reset();
        c0 = clicks;
        press(1'b0, 1'b1, 1'b0, 1160);
        checks++; if (target_pills1 !== 4'(exp_inc)) $display("FAIL repeat_digit got=%0d exp=%0d", target_pills1, exp_inc); else passes++;
        checks++; if (clicks - c0 != exp_inc) $display("FAIL repeat_click got=%0d exp=%0d", clicks - c0, exp_inc); else passes++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_random();
        test_validation();
        test_handshake();
        test_simultaneous();
        test_autorepeat();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
